// File: rtl/mylpm_addsub_pipe.sv
// mylpm_addsub_pipe: pipelined signed add/subtract with saturation, channel tag and sticky overflow
module mylpm_addsub_pipe #(
  parameter int WIDTH   = 16,
  parameter int LATENCY = 2,
  parameter int CHAN_W  = 2
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              enable,
  input  logic              strobe_in,
  input  logic              add_sub,
  input  logic              saturate,
  input  logic [WIDTH-1:0]  dataa,
  input  logic [WIDTH-1:0]  datab,
  input  logic [CHAN_W-1:0] chan_in,
  input  logic              clear_ovf,
  output logic [WIDTH-1:0]  result,
  output logic [CHAN_W-1:0] chan_out,
  output logic              strobe_out,
  output logic              overflow,
  output logic              ovf_sticky
);
  logic [WIDTH:0]     sum;
  logic               ovf;
  logic [WIDTH-1:0]   res;
  logic [LATENCY-1:0] v_q;
  logic [WIDTH-1:0]   d_q [LATENCY];
  logic [CHAN_W-1:0]  c_q [LATENCY];
  logic [LATENCY-1:0] o_q;
  // One-bit-wider arithmetic exposes overflow; clamp value follows the true sign in the extra bit
  always_comb begin
    sum = add_sub ? {dataa[WIDTH-1], dataa} + {datab[WIDTH-1], datab}
                  : {dataa[WIDTH-1], dataa} - {datab[WIDTH-1], datab};
    ovf = sum[WIDTH] ^ sum[WIDTH-1];
    res = (saturate && ovf) ? {sum[WIDTH], {(WIDTH-1){~sum[WIDTH]}}} : sum[WIDTH-1:0];
  end
  // Valid bits always shift; payload moves only with a valid sample so the last stage holds its result
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      v_q        <= '0;
      o_q        <= '0;
      ovf_sticky <= 1'b0;
      for (int i = 0; i < LATENCY; i++) begin
        d_q[i] <= '0;
        c_q[i] <= '0;
      end
    end else if (enable) begin
      v_q[0] <= strobe_in;
      if (strobe_in) begin
        d_q[0] <= res;
        c_q[0] <= chan_in;
        o_q[0] <= ovf;
      end
      for (int i = 1; i < LATENCY; i++) begin
        v_q[i] <= v_q[i-1];
        if (v_q[i-1]) begin
          d_q[i] <= d_q[i-1];
          c_q[i] <= c_q[i-1];
          o_q[i] <= o_q[i-1];
        end
      end
      ovf_sticky <= (strobe_out && overflow) ? 1'b1 : clear_ovf ? 1'b0 : ovf_sticky;
    end
  end
  assign result     = d_q[LATENCY-1];
  assign chan_out   = c_q[LATENCY-1];
  assign overflow   = o_q[LATENCY-1];
  assign strobe_out = v_q[LATENCY-1];
endmodule

// File: tb/tb_mylpm_addsub_pipe.sv
// tb_mylpm_addsub_pipe: scoreboard bench with directed vectors for mylpm_addsub_pipe
module tb_mylpm_addsub_pipe;
  localparam int LAT = 2;
  typedef struct {
    logic [15:0] r;
    logic        ov;
    logic [1:0]  ch;
    int          issue;
    int          wissue;
    int          ext;
  } exp_t;
  logic        clock = 1'b0;
  logic        reset_n = 1'b1;
  logic        enable = 1'b1;
  logic        strobe_in = 1'b0;
  logic        add_sub = 1'b0;
  logic        saturate = 1'b0;
  logic [15:0] dataa = '0;
  logic [15:0] datab = '0;
  logic [1:0]  chan_in = '0;
  logic        clear_ovf = 1'b0;
  logic [15:0] result;
  logic [1:0]  chan_out;
  logic        strobe_out;
  logic        overflow;
  logic        ovf_sticky;
  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          ecnt = 0;
  int          wcnt = 0;
  int          last = -1;
  int          nstrobe = 0;
  int          s0;

  mylpm_addsub_pipe #(.WIDTH(16), .LATENCY(LAT), .CHAN_W(2)) dut (
    .clock(clock), .reset_n(reset_n), .enable(enable), .strobe_in(strobe_in),
    .add_sub(add_sub), .saturate(saturate), .dataa(dataa), .datab(datab),
    .chan_in(chan_in), .clear_ovf(clear_ovf), .result(result), .chan_out(chan_out),
    .strobe_out(strobe_out), .overflow(overflow), .ovf_sticky(ovf_sticky)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    wcnt++;
    if (reset_n && enable) ecnt++;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  always @(negedge clock) begin
    if (reset_n && strobe_out && ecnt != last) begin
      last = ecnt;
      nstrobe++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_strobe actual=1 expected=0 result=%h", result);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("result", {16'h0, result}, {16'h0, e.r});
        chk("overflow", {31'h0, overflow}, {31'h0, e.ov});
        chk("chan_out", {30'h0, chan_out}, {30'h0, e.ch});
        chk("latency_enabled", ecnt - e.issue, LAT);
        chk("latency_wall", wcnt - e.wissue, LAT + e.ext);
      end
    end
  end

  task automatic drive(input logic s, input logic [15:0] a, input logic [15:0] b,
                       input logic add, input logic sat, input logic [1:0] ch,
                       input logic clr, input logic en);
    @(negedge clock);
    strobe_in = s; dataa = a; datab = b; add_sub = add; saturate = sat;
    chan_in = ch; clear_ovf = clr; enable = en;
  endtask

  task automatic idle(input int n, input logic clr);
    repeat (n) drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 2'd0, clr, 1'b1);
  endtask

  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic add,
                      input logic sat, input logic [1:0] ch, input logic [15:0] er,
                      input logic eo, input int ext);
    drive(1'b1, a, b, add, sat, ch, 1'b0, 1'b1);
    sb.push_back('{er, eo, ch, ecnt, wcnt, ext});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #2 reset_n = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_result", {16'h0, result}, 32'h0);
    chk("rst_chan", {30'h0, chan_out}, 32'h0);
    chk("rst_strobe", {31'h0, strobe_out}, 32'h0);
    chk("rst_overflow", {31'h0, overflow}, 32'h0);
    chk("rst_sticky", {31'h0, ovf_sticky}, 32'h0);
    reset_n = 1'b1;
    send(16'h1234, 16'h0001, 1'b1, 1'b0, 2'd0, 16'h1235, 1'b0, 0);
    send(16'h0005, 16'h0007, 1'b0, 1'b1, 2'd1, 16'hFFFE, 1'b0, 0);
    idle(3, 1'b0);
    chk("sticky_clean", {31'h0, ovf_sticky}, 32'h0);
    send(16'h7FFF, 16'h0001, 1'b1, 1'b1, 2'd2, 16'h7FFF, 1'b1, 0);
    send(16'h7FFF, 16'h0001, 1'b1, 1'b0, 2'd3, 16'h8000, 1'b1, 0);
    send(16'h8000, 16'h0001, 1'b0, 1'b1, 2'd0, 16'h8000, 1'b1, 0);
    send(16'h0000, 16'h8000, 1'b0, 1'b1, 2'd1, 16'h7FFF, 1'b1, 0);
    idle(3, 1'b0);
    chk("sticky_set", {31'h0, ovf_sticky}, 32'h1);
    send(16'h0010, 16'h0001, 1'b1, 1'b0, 2'd0, 16'h0011, 1'b0, 0);
    send(16'h0100, 16'h0001, 1'b0, 1'b0, 2'd1, 16'h00FF, 1'b0, 3);
    repeat (3) drive(1'b1, 16'hAAAA, 16'h5555, 1'b1, 1'b0, 2'd3, 1'b0, 1'b0);
    send(16'hFFFF, 16'hFFFF, 1'b1, 1'b1, 2'd2, 16'hFFFE, 1'b0, 0);
    send(16'h8000, 16'h8000, 1'b1, 1'b0, 2'd3, 16'h0000, 1'b1, 0);
    idle(3, 1'b0);
    send(16'h0001, 16'h0002, 1'b1, 1'b0, 2'd1, 16'h0003, 1'b0, 0);
    send(16'h0004, 16'h0002, 1'b0, 1'b0, 2'd2, 16'h0002, 1'b0, 0);
    @(posedge clock);
    #1;
    reset_n = 1'b0;
    strobe_in = 1'b0;
    sb.delete();
    #1;
    chk("midrst_result", {16'h0, result}, 32'h0);
    chk("midrst_chan", {30'h0, chan_out}, 32'h0);
    chk("midrst_strobe", {31'h0, strobe_out}, 32'h0);
    chk("midrst_overflow", {31'h0, overflow}, 32'h0);
    chk("midrst_sticky", {31'h0, ovf_sticky}, 32'h0);
    @(posedge clock);
    #1 reset_n = 1'b1;
    s0 = nstrobe;
    idle(5, 1'b0);
    chk("no_strobe_after_rst", nstrobe - s0, 0);
    send(16'h7FFF, 16'h0001, 1'b1, 1'b1, 2'd2, 16'h7FFF, 1'b1, 0);
    idle(1, 1'b0);
    idle(1, 1'b1);
    idle(1, 1'b0);
    chk("sticky_set_wins", {31'h0, ovf_sticky}, 32'h1);
    idle(1, 1'b1);
    idle(1, 1'b0);
    chk("sticky_cleared", {31'h0, ovf_sticky}, 32'h0);
    for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clock);
    if (sb.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain actual=%0d pending expected=0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
